// File: rtl/fb_bus_arbiter.sv
// Two-port pipelined Wishbone arbiter for framebuffer memory: video fetch vs CPU window.
// Optional CPU anti-starvation timer enabled by defining FB_ARB_STARVE_EN.
module fb_bus_arbiter #(
  parameter int OCNT_W       = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // video fetch port (read-only traffic)
  input  logic        video_cyc_i,
  input  logic        video_stb_i,
  input  logic        video_we_i,
  input  logic [3:0]  video_sel_i,
  input  logic [31:0] video_adr_i,
  input  logic [31:0] video_dat_i,
  output logic        video_stall_o,
  output logic        video_ack_o,
  output logic [31:0] video_dat_o,
  // cpu framebuffer window port
  input  logic        cpu_cyc_i,
  input  logic        cpu_stb_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_adr_i,
  input  logic [31:0] cpu_dat_i,
  output logic        cpu_stall_o,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_dat_o,
  // shared memory port
  output logic        mem_cyc_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_sel_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic        mem_stall_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i,
  output logic [1:0]  owner_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VIDEO = 2'd1;
  localparam logic [1:0] S_CPU   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;
  localparam logic [OCNT_W-1:0] OCNT_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic              vid_g, cpu_g, grant, full, ack_ok, inc, starve_win;
  logic              own_cyc, own_stb, own_we;
  logic [3:0]        own_sel;
  logic [31:0]       own_adr, own_dat;

  assign vid_g   = (state_q == S_VIDEO);
  assign cpu_g   = (state_q == S_CPU);
  assign grant   = vid_g | cpu_g;
  assign full    = (ocnt_q == OCNT_MAX);
  // acks with nothing outstanding are stale (e.g. from before a reset)
  assign ack_ok  = mem_ack_i & (ocnt_q != '0);
  assign owner_o = state_q;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    if (vid_g) begin
      own_cyc = video_cyc_i;
      own_stb = video_stb_i;
      own_we  = video_we_i;
      own_sel = video_sel_i;
      own_adr = video_adr_i;
      own_dat = video_dat_i;
    end else if (cpu_g) begin
      own_cyc = cpu_cyc_i;
      own_stb = cpu_stb_i;
      own_we  = cpu_we_i;
      own_sel = cpu_sel_i;
      own_adr = cpu_adr_i;
      own_dat = cpu_dat_i;
    end
  end

  assign mem_cyc_o = (state_q == S_DRAIN) | (grant & own_cyc);
  assign mem_stb_o = grant & own_cyc & own_stb & ~full;
  assign mem_we_o  = own_we;
  assign mem_sel_o = own_sel;
  assign mem_adr_o = own_adr;
  assign mem_dat_o = own_dat;

  assign video_stall_o = ~vid_g | mem_stall_i | full;
  assign video_ack_o   = vid_g & ack_ok;
  assign video_dat_o   = vid_g ? mem_dat_i : '0;
  assign cpu_stall_o   = ~cpu_g | mem_stall_i | full;
  assign cpu_ack_o     = cpu_g & ack_ok;
  assign cpu_dat_o     = cpu_g ? mem_dat_i : '0;

  assign inc = mem_stb_o & ~mem_stall_i;

  always_comb begin
    ocnt_d = ocnt_q;
    if (inc && !ack_ok)      ocnt_d = ocnt_q + 1'b1;
    else if (!inc && ack_ok) ocnt_d = ocnt_q - 1'b1;
  end

  // Grant is held for the whole cyc window; leaving it waits for outstanding acks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_cyc_i && starve_win) state_d = S_CPU;
        else if (video_cyc_i)        state_d = S_VIDEO;
        else if (cpu_cyc_i)          state_d = S_CPU;
      end
      S_VIDEO: if (!video_cyc_i) state_d = (ocnt_d == '0) ? S_IDLE : S_DRAIN;
      S_CPU:   if (!cpu_cyc_i)   state_d = (ocnt_d == '0) ? S_IDLE : S_DRAIN;
      default: if (ocnt_d == '0) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ocnt_q  <= ocnt_d;
    end
  end

`ifdef FB_ARB_STARVE_EN
  localparam int TW = $clog2(STARVE_LIMIT + 1);
  logic [TW-1:0] starve_q, starve_d;

  assign starve_win = (starve_q >= TW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (cpu_g)                          starve_d = '0;
    else if (cpu_cyc_i && !starve_win)  starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) starve_q <= '0;
    else         starve_q <= starve_d;
  end
`else
  assign starve_win = 1'b0;
`endif

endmodule

// File: tb/tb_fb_bus_arbiter.sv
// Scoreboard bench for fb_bus_arbiter: memory model with 2-cycle ack latency,
// per-port expected-data queues filled on accept and drained on ack.
module tb_fb_bus_arbiter;
  localparam int OCNT_W = 2;
  localparam int LIMIT  = 4;
  localparam int LAT    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        video_cyc_i = 0, video_stb_i = 0, video_we_i = 0;
  logic [3:0]  video_sel_i = 4'hf;
  logic [31:0] video_adr_i = 0, video_dat_i = 0;
  logic        video_stall_o, video_ack_o;
  logic [31:0] video_dat_o;
  logic        cpu_cyc_i = 0, cpu_stb_i = 0, cpu_we_i = 0;
  logic [3:0]  cpu_sel_i = 4'hf;
  logic [31:0] cpu_adr_i = 0, cpu_dat_i = 0;
  logic        cpu_stall_o, cpu_ack_o;
  logic [31:0] cpu_dat_o;
  logic        mem_cyc_o, mem_stb_o, mem_we_o;
  logic [3:0]  mem_sel_o;
  logic [31:0] mem_adr_o, mem_dat_o;
  logic        mem_stall_i = 0, mem_ack_i = 0;
  logic [31:0] mem_dat_i = 0;
  logic [1:0]  owner_o;

  fb_bus_arbiter #(.OCNT_W(OCNT_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .video_cyc_i(video_cyc_i), .video_stb_i(video_stb_i), .video_we_i(video_we_i),
    .video_sel_i(video_sel_i), .video_adr_i(video_adr_i), .video_dat_i(video_dat_i),
    .video_stall_o(video_stall_o), .video_ack_o(video_ack_o), .video_dat_o(video_dat_o),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_stall_o(cpu_stall_o), .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o),
    .mem_stall_i(mem_stall_i), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
    .owner_o(owner_o)
  );

  int vecs = 0, errs = 0;
  int cyc_no = 0;
  logic [31:0] sb_v[$], sb_c[$];
  int          mq_due[$];
  logic [31:0] mq_adr[$];
  bit ack_en = 1;
  bit v_acc, c_acc;
  int v_acks = 0, c_acks = 0, side_bad = 0;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  // One clock: sample just before the rising edge, then advance the memory model.
  task automatic tick();
    logic [31:0] e;
    #1;
    v_acc = video_cyc_i && video_stb_i && !video_stall_o;
    c_acc = cpu_cyc_i && cpu_stb_i && !cpu_stall_o;
    if (v_acc) sb_v.push_back(mdat(video_adr_i));
    if (c_acc) sb_c.push_back(mdat(cpu_adr_i));
    if (mem_stb_o && !mem_stall_i) begin
      mq_due.push_back(cyc_no + LAT);
      mq_adr.push_back(mem_adr_o);
    end
    if (video_ack_o) begin
      vecs++; v_acks++;
      if (sb_v.size() == 0) begin
        errs++; $display("FAIL video_ack_unexpected: got ack with dat=%h, required no ack", video_dat_o);
      end else begin
        e = sb_v.pop_front();
        if (video_dat_o !== e) begin errs++; $display("FAIL video_rdata: got %h, required %h", video_dat_o, e); end
      end
    end
    if (cpu_ack_o) begin
      vecs++; c_acks++;
      if (sb_c.size() == 0) begin
        errs++; $display("FAIL cpu_ack_unexpected: got ack with dat=%h, required no ack", cpu_dat_o);
      end else begin
        e = sb_c.pop_front();
        if (cpu_dat_o !== e) begin errs++; $display("FAIL cpu_rdata: got %h, required %h", cpu_dat_o, e); end
      end
    end
    @(negedge clk);
    cyc_no++;
    mem_ack_i = 0; mem_dat_i = 0;
    if (ack_en && mq_due.size() > 0 && mq_due[0] <= cyc_no) begin
      mem_ack_i = 1;
      mem_dat_i = mdat(mq_adr.pop_front());
      void'(mq_due.pop_front());
    end
  endtask

  task automatic run_video(input int n, input logic [31:0] base, output bit ok);
    int issued = 0, guard = 0;
    v_acks = 0;
    video_cyc_i = 1;
    while ((issued < n || sb_v.size() != 0) && guard < 4000) begin
      video_stb_i = (issued < n);
      video_adr_i = base + issued;
      #1;
      if (owner_o != 2'd2 && (cpu_stall_o !== 1'b1 || cpu_ack_o !== 1'b0)) side_bad++;
      tick();
      if (v_acc) issued++;
      guard++;
    end
    video_stb_i = 0;
    ok = (guard < 4000);
  endtask

  task automatic run_cpu(input int n, input logic [31:0] base, output bit ok);
    int issued = 0, guard = 0;
    c_acks = 0;
    cpu_cyc_i = 1; cpu_we_i = 1;
    while ((issued < n || sb_c.size() != 0) && guard < 4000) begin
      cpu_stb_i = (issued < n);
      cpu_adr_i = base + issued;
      cpu_dat_i = ~(base + issued);
      tick();
      if (c_acc) issued++;
      guard++;
    end
    cpu_stb_i = 0; cpu_we_i = 0;
    ok = (guard < 4000);
  endtask

  task automatic test_reset();
    rst_n = 0;
    video_cyc_i = 1; video_stb_i = 1;
    cpu_cyc_i = 1; cpu_stb_i = 1; cpu_we_i = 1;
    tick(); tick();
    mem_ack_i = 1;
    #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL reset_owner: got %0d, required 0", owner_o); end
    vecs++; if ({mem_cyc_o, mem_stb_o, mem_we_o} !== 3'b000) begin errs++; $display("FAIL reset_mem_ctl: got cyc/stb/we=%b, required 000", {mem_cyc_o, mem_stb_o, mem_we_o}); end
    vecs++; if ({video_stall_o, cpu_stall_o} !== 2'b11) begin errs++; $display("FAIL reset_stall: got %b, required 11", {video_stall_o, cpu_stall_o}); end
    vecs++; if ({video_ack_o, cpu_ack_o} !== 2'b00) begin errs++; $display("FAIL reset_ack: got %b, required 00", {video_ack_o, cpu_ack_o}); end
    video_cyc_i = 0; video_stb_i = 0;
    cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0;
    mem_ack_i = 0;
    @(negedge clk); rst_n = 1;
    tick();
  endtask

  task automatic test_video_burst();
    bit ok;
    side_bad = 0;
    video_cyc_i = 1; video_stb_i = 1; video_adr_i = 32'h1000;
    #1;
    vecs++; if ({owner_o, mem_stb_o} !== 3'b000) begin errs++; $display("FAIL lat_idle: got owner/stb=%b, required 000", {owner_o, mem_stb_o}); end
    tick(); #1;
    vecs++; if ({owner_o, mem_stb_o} !== 3'b011) begin errs++; $display("FAIL lat_first_stb: got owner/stb=%b, required 011", {owner_o, mem_stb_o}); end
    run_video(160, 32'h1000, ok);
    vecs++; if (!ok) begin errs++; $display("FAIL burst_timeout: got timeout, required completion"); end
    vecs++; if (v_acks != 160) begin errs++; $display("FAIL burst_acks: got %0d, required 160", v_acks); end
    vecs++; if (side_bad != 0) begin errs++; $display("FAIL burst_cpu_stall: got %0d bad cycles, required 0", side_bad); end
    #1;
    vecs++; if (owner_o !== 2'd1) begin errs++; $display("FAIL burst_hold: got owner %0d, required 1", owner_o); end
    video_cyc_i = 0;
    tick(); #1;
    vecs++; if (owner_o !== 2'd0 || mem_cyc_o !== 1'b0) begin errs++; $display("FAIL burst_release: got owner %0d cyc %b, required 0 0", owner_o, mem_cyc_o); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    side_bad = 0;
    video_cyc_i = 1; cpu_cyc_i = 1; cpu_stb_i = 1; cpu_adr_i = 32'h8000;
    tick(); #1;
    vecs++; if (owner_o !== 2'd1) begin errs++; $display("FAIL sim_first: got owner %0d, required 1", owner_o); end
    run_video(4, 32'h2000, ok);
    vecs++; if (!ok || v_acks != 4) begin errs++; $display("FAIL sim_video: got %0d acks ok=%0d, required 4 acks", v_acks, ok); end
    vecs++; if (side_bad != 0) begin errs++; $display("FAIL sim_cpu_blocked: got %0d bad cycles, required 0", side_bad); end
    video_cyc_i = 0;
    tick(); #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL sim_idle: got owner %0d, required 0", owner_o); end
    tick(); #1;
    vecs++; if (owner_o !== 2'd2) begin errs++; $display("FAIL sim_cpu_grant: got owner %0d, required 2", owner_o); end
    run_cpu(2, 32'h8000, ok);
    vecs++; if (!ok || c_acks != 2) begin errs++; $display("FAIL sim_cpu_acks: got %0d, required 2", c_acks); end
    cpu_cyc_i = 0;
    tick(); #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL sim_release: got owner %0d, required 0", owner_o); end
  endtask

  task automatic test_abort_drain();
    int issued = 0, guard = 0, absorbed = 0, fwd = 0, cyc_bad = 0;
    ack_en = 0;
    cpu_cyc_i = 1; cpu_stb_i = 1;
    while (issued < 3 && guard < 20) begin
      cpu_adr_i = 32'h9000 + issued;
      tick();
      if (c_acc) issued++;
      guard++;
    end
    cpu_stb_i = 0; cpu_cyc_i = 0;
    tick(); #1;
    vecs++; if (owner_o !== 2'd3 || mem_cyc_o !== 1'b1 || mem_stb_o !== 1'b0) begin errs++; $display("FAIL drain_enter: got owner %0d cyc %b stb %b, required 3 1 0", owner_o, mem_cyc_o, mem_stb_o); end
    sb_c.delete();
    ack_en = 1;
    guard = 0;
    while (owner_o == 2'd3 && guard < 20) begin
      #1;
      if (mem_ack_i) absorbed++;
      if (cpu_ack_o) fwd++;
      if (mem_cyc_o !== 1'b1) cyc_bad++;
      tick();
      guard++;
    end
    #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL drain_exit: got owner %0d, required 0", owner_o); end
    vecs++; if (absorbed != 3 || fwd != 0) begin errs++; $display("FAIL drain_absorb: got %0d absorbed %0d forwarded, required 3 0", absorbed, fwd); end
    vecs++; if (cyc_bad != 0) begin errs++; $display("FAIL drain_cyc: got %0d cycles without cyc, required 0", cyc_bad); end
  endtask

  task automatic test_saturation();
    int acc = 0, guard = 0;
    ack_en = 0;
    video_cyc_i = 1; video_stb_i = 1; video_adr_i = 32'h3000;
    tick();
    mem_stall_i = 1;
    #1;
    vecs++; if (video_stall_o !== 1'b1 || mem_stb_o !== 1'b1) begin errs++; $display("FAIL mem_stall_pass: got stall %b stb %b, required 1 1", video_stall_o, mem_stb_o); end
    tick();
    mem_stall_i = 0;
    repeat (8) begin
      tick();
      if (v_acc) begin acc++; video_adr_i = video_adr_i + 1; end
    end
    #1;
    vecs++; if (acc != 3) begin errs++; $display("FAIL sat_accepted: got %0d, required 3", acc); end
    vecs++; if (video_stall_o !== 1'b1 || mem_stb_o !== 1'b0) begin errs++; $display("FAIL sat_block: got stall %b stb %b, required 1 0", video_stall_o, mem_stb_o); end
    video_stb_i = 0;
    ack_en = 1;
    v_acks = 0;
    while (sb_v.size() != 0 && guard < 40) begin tick(); guard++; end
    vecs++; if (v_acks != 3) begin errs++; $display("FAIL sat_drain_acks: got %0d, required 3", v_acks); end
    video_cyc_i = 0;
    tick(); #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL sat_release: got owner %0d, required 0", owner_o); end
  endtask

  task automatic test_reset_midburst();
    int acc = 0, guard = 0, late = 0;
    bit ok;
    video_cyc_i = 1; video_stb_i = 1;
    while (acc < 10 && guard < 100) begin
      video_adr_i = 32'h4000 + acc;
      tick();
      if (v_acc) acc++;
      guard++;
    end
    ack_en = 0;
    rst_n = 0;
    #1;
    vecs++; if ({owner_o, mem_cyc_o, mem_stb_o, mem_we_o} !== 5'b00000) begin errs++; $display("FAIL rst_mid_mem: got owner/cyc/stb/we=%b, required 00000", {owner_o, mem_cyc_o, mem_stb_o, mem_we_o}); end
    vecs++; if ({video_stall_o, cpu_stall_o, video_ack_o, cpu_ack_o} !== 4'b1100) begin errs++; $display("FAIL rst_mid_ports: got stall/ack=%b, required 1100", {video_stall_o, cpu_stall_o, video_ack_o, cpu_ack_o}); end
    tick();
    video_cyc_i = 0; video_stb_i = 0;
    sb_v.delete();
    rst_n = 1;
    ack_en = 1;
    guard = 0;
    while (mq_due.size() != 0 && guard < 40) begin
      #1;
      if (video_ack_o || cpu_ack_o) late++;
      tick();
      guard++;
    end
    #1;
    vecs++; if (late != 0 || owner_o !== 2'd0) begin errs++; $display("FAIL rst_late_acks: got %0d forwarded owner %0d, required 0 0", late, owner_o); end
    run_video(4, 32'h5000, ok);
    vecs++; if (!ok || v_acks != 4) begin errs++; $display("FAIL rst_post_burst: got %0d acks ok=%0d, required 4", v_acks, ok); end
    video_cyc_i = 0;
    tick();
  endtask

  task automatic test_starve();
    bit ok;
    logic [1:0] exp;
`ifdef FB_ARB_STARVE_EN
    exp = 2'd2;
`else
    exp = 2'd1;
`endif
    cpu_cyc_i = 1; cpu_stb_i = 0;
    run_video(8, 32'h6000, ok);
    video_cyc_i = 0;
    tick();
    video_cyc_i = 1;
    #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL starve_idle: got owner %0d, required 0", owner_o); end
    tick(); #1;
    vecs++; if (owner_o !== exp) begin errs++; $display("FAIL starve_grant: got owner %0d, required %0d", owner_o, exp); end
    video_cyc_i = 0; cpu_cyc_i = 0;
    tick(); tick(); #1;
    vecs++; if (owner_o !== 2'd0) begin errs++; $display("FAIL starve_release: got owner %0d, required 0", owner_o); end
  endtask

  initial begin
    test_reset();
    test_video_burst();
    test_simultaneous();
    test_abort_drain();
    test_saturation();
    test_reset_midburst();
    test_starve();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "timeout");
  end
endmodule
